// File: rtl/fsm_basics_pkg.sv
// fsm_basics_pkg: shared state codes and idle line level for the serial pattern transmitter
package fsm_basics_pkg;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_GAP    = 2'd3;
    localparam logic LINE_IDLE = 1'b0;
    typedef enum logic [1:0] {IDLE = S_IDLE, SHIFT = S_SHIFT, PARITY = S_PARITY, GAP = S_GAP} state_e;
endpackage

// File: rtl/pattern_tx_cnt.sv
// pattern_tx_cnt: loadable down-counter with zero flag, stops at zero
module pattern_tx_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load ? load_val : (en && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/pattern_tx.sv
// pattern_tx: MSB-first serial pattern transmitter with inter-frame gap; even parity bit when PATTERN_TX_PARITY_EN is defined
module pattern_tx
    import fsm_basics_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = $clog2(WIDTH + GAP_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pat_i,
    input  logic             pat_valid_i,
    output logic             pat_ready_o,
    output logic             a_o,
    output logic             frame_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam logic [CNT_W-1:0] SHIFT_LD = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    localparam state_e POST = (GAP_CYCLES > 0) ? GAP : IDLE;
    state_e state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic a_q, a_d, frame_q, frame_d, ld, en, zero;
    logic [CNT_W-1:0] ld_val;
`ifdef PATTERN_TX_PARITY_EN
    logic par_q, par_d;
`endif
    pattern_tx_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk(clk), .rst(rst), .load(ld), .en(en), .load_val(ld_val), .zero_o(zero)
    );
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        a_d     = LINE_IDLE;
        frame_d = 1'b0;
        ld      = 1'b0;
        en      = 1'b0;
        ld_val  = SHIFT_LD;
`ifdef PATTERN_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: if (pat_valid_i && pat_ready_o) begin
                state_d = SHIFT;
                sh_d    = pat_i << 1;
                a_d     = pat_i[WIDTH-1];
                frame_d = 1'b1;
                ld      = 1'b1;
`ifdef PATTERN_TX_PARITY_EN
                par_d   = ^pat_i;
`endif
            end
            SHIFT: if (!zero) begin
                sh_d    = sh_q << 1;
                a_d     = sh_q[WIDTH-1];
                frame_d = 1'b1;
                en      = 1'b1;
            end else begin
`ifdef PATTERN_TX_PARITY_EN
                state_d = PARITY;
                a_d     = par_q;
                frame_d = 1'b1;
            end
            PARITY: begin
`endif
                state_d = POST;
                ld      = GAP_CYCLES > 0;
                ld_val  = GAP_LD;
            end
            GAP: if (zero) state_d = IDLE; else en = 1'b1;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            a_q     <= LINE_IDLE;
            frame_q <= 1'b0;
`ifdef PATTERN_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            a_q     <= a_d;
            frame_q <= frame_d;
`ifdef PATTERN_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end
    assign pat_ready_o = state_q == IDLE && !rst;
    assign busy_o      = state_q != IDLE;
    assign a_o         = a_q;
    assign frame_o     = frame_q;
`ifdef PATTERN_TX_PARITY_EN
    assign done_o = (GAP_CYCLES > 0) ? (state_q == GAP && zero) : (state_q == PARITY);
`else
    assign done_o = (GAP_CYCLES > 0) ? (state_q == GAP && zero) : (state_q == SHIFT && zero);
`endif
endmodule
